// File: rtl/net_layer_seq.sv
// Sequencer for one fully-connected layer on a shared FP32 MAC and activation unit.
// Build option: define LAYER_SEQ_BIAS_EN to add a per-neuron bias MAC (operand 1.0).
module net_layer_seq #(
  parameter int NI = 2,
  parameter int NO = 4,
  parameter int AW = 8,
  localparam int XW = (NI > 1) ? $clog2(NI) : 1,
  localparam int YW = (NO > 1) ? $clog2(NO) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] w_addr,
  output logic [XW-1:0] x_sel,
  output logic          mac_clr,
  output logic          mac_req,
  input  logic          mac_ack,
  output logic          act_req,
  input  logic          act_ack,
  output logic          y_we,
  output logic [YW-1:0] y_idx
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_MAC, S_GAP, S_BGAP, S_BIAS, S_ACT, S_WB, S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_W    = AW'(NI * NO - 1);
  localparam logic [AW-1:0] BIAS_BASE = AW'(NI * NO);
  localparam logic [XW-1:0] LAST_I    = XW'(NI - 1);
  localparam logic [YW-1:0] LAST_J    = YW'(NO - 1);

  state_t        r_state, w_state_nxt;
  logic [XW-1:0] r_i, w_i_nxt;
  logic [YW-1:0] r_j, w_j_nxt;
  logic [AW-1:0] r_wcnt, w_wcnt_nxt;

  logic          w_busy_d, w_done_d, w_mac_clr_d, w_mac_req_d, w_act_req_d, w_y_we_d;
  logic [AW-1:0] w_addr_d;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nxt = S_CLR;
        w_i_nxt     = '0;
        w_j_nxt     = '0;
        w_wcnt_nxt  = '0;
      end
      S_CLR: w_state_nxt = S_MAC;
      S_MAC: if (mac_ack) begin
        // Wrap keeps the running address inside the weight block after the last neuron.
        w_wcnt_nxt = (r_wcnt == LAST_W) ? '0 : r_wcnt + AW'(1);
        if (r_i == LAST_I) begin
          w_i_nxt = '0;
`ifdef LAYER_SEQ_BIAS_EN
          w_state_nxt = S_BGAP;
`else
          w_state_nxt = S_ACT;
`endif
        end else begin
          w_i_nxt     = r_i + XW'(1);
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: w_state_nxt = S_MAC;
`ifdef LAYER_SEQ_BIAS_EN
      S_BGAP: w_state_nxt = S_BIAS;
      S_BIAS: if (mac_ack) w_state_nxt = S_ACT;
`endif
      S_ACT: if (act_ack) w_state_nxt = S_WB;
      S_WB: begin
        if (r_j == LAST_J) begin
          w_state_nxt = S_DONE;
        end else begin
          w_j_nxt     = r_j + YW'(1);
          w_state_nxt = S_CLR;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with r_state.
  always_comb begin
    w_busy_d    = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_done_d    = (w_state_nxt == S_DONE);
    w_mac_clr_d = (w_state_nxt == S_CLR);
    w_mac_req_d = (w_state_nxt == S_MAC) || (w_state_nxt == S_BIAS);
    w_act_req_d = (w_state_nxt == S_ACT);
    w_y_we_d    = (w_state_nxt == S_WB);
    w_addr_d    = w_wcnt_nxt;
`ifdef LAYER_SEQ_BIAS_EN
    if ((w_state_nxt == S_BGAP) || (w_state_nxt == S_BIAS))
      w_addr_d = BIAS_BASE + AW'(w_j_nxt);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      mac_clr <= 1'b0;
      mac_req <= 1'b0;
      act_req <= 1'b0;
      y_we    <= 1'b0;
      w_addr  <= '0;
      x_sel   <= '0;
      y_idx   <= '0;
    end else begin
      busy    <= w_busy_d;
      done    <= w_done_d;
      mac_clr <= w_mac_clr_d;
      mac_req <= w_mac_req_d;
      act_req <= w_act_req_d;
      y_we    <= w_y_we_d;
      w_addr  <= w_addr_d;
      x_sel   <= w_i_nxt;
      y_idx   <= w_j_nxt;
    end
  end

endmodule

// File: tb/tb_net_layer_seq.sv
// Self-checking bench for net_layer_seq: vector table, random ack delays, reset and corner runs.
// Honours LAYER_SEQ_BIAS_EN when the bundle is built with it.
module tb_net_layer_seq;

  localparam int NI = 2;
  localparam int NO = 4;
  localparam int AW = 8;
`ifdef LAYER_SEQ_BIAS_EN
  localparam int BIAS = 1;
`else
  localparam int BIAS = 0;
`endif
  localparam int PER = 2 * NI + 2 + 2 * BIAS;  // cycles per neuron, zero-wait acks
  localparam int T   = NO * PER + 1;           // done cycle, zero-wait acks
  localparam int OPS = NO * (NI + BIAS);       // MAC operations per layer
  localparam int LOG = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, mac_ack = 1'b0, act_ack = 1'b0;
  logic busy, done, mac_clr, mac_req, act_req, y_we;
  logic [AW-1:0] w_addr;
  logic [0:0] x_sel;
  logic [1:0] y_idx;

  logic s_start = 1'b0, s_mac_ack = 1'b0, s_act_ack = 1'b0;
  logic s_busy, s_done, s_mac_clr, s_mac_req, s_act_req, s_y_we;
  logic [AW-1:0] s_w_addr;
  logic [0:0] s_x_sel, s_y_idx;

  always #5 clk = ~clk;

  net_layer_seq #(.NI(NI), .NO(NO), .AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_addr(w_addr), .x_sel(x_sel), .mac_clr(mac_clr), .mac_req(mac_req),
    .mac_ack(mac_ack), .act_req(act_req), .act_ack(act_ack), .y_we(y_we), .y_idx(y_idx));

  net_layer_seq #(.NI(1), .NO(1), .AW(AW)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .w_addr(s_w_addr), .x_sel(s_x_sel), .mac_clr(s_mac_clr), .mac_req(s_mac_req),
    .mac_ack(s_mac_ack), .act_req(s_act_req), .act_ack(s_act_ack), .y_we(s_y_we),
    .y_idx(s_y_idx));

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: operand order of one layer, straight from the addressing rules.
  int exp_addr[$], exp_xsel[$];
  initial begin
    for (int j = 0; j < NO; j++) begin
      for (int i = 0; i < NI; i++) begin
        exp_addr.push_back(j * NI + i);
        exp_xsel.push_back(i);
      end
      if (BIAS != 0) begin
        exp_addr.push_back(NI * NO + j);
        exp_xsel.push_back(0);
      end
    end
  end

  // Monitor and ack responder share one negedge process.
  int  ncyc = 0, t_start = 0, rel;
  bit  armed = 0, started = 0, noise = 0, prev_req = 0;
  bit  busy_log[LOG];
  int  n_done, first_done, last_done, mac_rises, clr_cnt, overlap, sum_delay;
  int  ops_addr[$], ops_xsel[$], y_log[$];
  int  md_cfg = 0, ad_cfg = 0, mac_wait = 0, act_wait = 0, cur_md = 0, cur_ad = 0;

  always @(negedge clk) begin
    ncyc++;
    if (armed && !started && start) begin
      started = 1;
      t_start = ncyc;
    end
    if (started) begin
      rel = ncyc - t_start;
      if (rel < LOG) busy_log[rel] = busy;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = rel;
        last_done = rel;
      end
      if (mac_req && !prev_req) mac_rises++;
      if (mac_clr) clr_cnt++;
      if (mac_req && act_req) overlap++;
      if (y_we) y_log.push_back(int'(y_idx));
    end
    prev_req = mac_req;
    if (!rst_n) begin
      mac_ack = 1'b0; act_ack = 1'b0; mac_wait = 0; act_wait = 0;
    end else begin
      if (mac_req) begin
        if (mac_wait == 0) begin
          cur_md = (md_cfg < 0) ? int'($urandom_range(0, 3)) : md_cfg;
          sum_delay += cur_md;
        end
        mac_ack = (mac_wait == cur_md);
        if (mac_ack && started) begin
          ops_addr.push_back(int'(w_addr));
          ops_xsel.push_back(int'(x_sel));
        end
        mac_wait++;
      end else begin
        mac_wait = 0;
        mac_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (act_req) begin
        if (act_wait == 0) begin
          cur_ad = (ad_cfg < 0) ? int'($urandom_range(0, 3)) : ad_cfg;
          sum_delay += cur_ad;
        end
        act_ack = (act_wait == cur_ad);
        act_wait++;
      end else begin
        act_wait = 0;
        act_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic clear_logs();
    started = 0; n_done = 0; first_done = -1; last_done = -1;
    mac_rises = 0; clr_cnt = 0; overlap = 0; sum_delay = 0;
    ops_addr.delete(); ops_xsel.delete(); y_log.delete();
    for (int c = 0; c < LOG; c++) busy_log[c] = 1'b0;
  endtask

  task automatic run_layer(input int md, input int ad, input bit nz, input int hold,
                           input int layers);
    bit ok = 0;
    clear_logs();
    md_cfg = md; ad_cfg = ad; noise = nz; armed = 1;
    @(posedge clk); #2 start = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (c >= hold) start = 1'b0;
      if (n_done >= layers && last_done >= 0 && (ncyc - t_start) >= last_done + 3) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0; armed = 0; noise = 0;
    if (!ok) check("layer_timeout", n_done, layers);
  endtask

  task automatic verify(input string tag, input int exp_done, input int layers);
    int n_ops, bc;
    n_ops = layers * OPS;
    check({tag, " done_cycle"}, first_done, exp_done);
    check({tag, " done_pulses"}, n_done, layers);
    check({tag, " mac_ops"}, ops_addr.size(), n_ops);
    check({tag, " mac_req_rises"}, mac_rises, n_ops);
    check({tag, " mac_clr_pulses"}, clr_cnt, layers * NO);
    check({tag, " req_overlap"}, overlap, 0);
    check({tag, " y_we_count"}, y_log.size(), layers * NO);
    for (int k = 0; k < ops_addr.size() && k < n_ops; k++) begin
      check($sformatf("%s op%0d w_addr", tag, k), ops_addr[k], exp_addr[k % OPS]);
      check($sformatf("%s op%0d x_sel", tag, k), ops_xsel[k], exp_xsel[k % OPS]);
    end
    for (int k = 0; k < y_log.size() && k < layers * NO; k++)
      check($sformatf("%s y_idx%0d", tag, k), y_log[k], k % NO);
    if (layers == 1 && exp_done < LOG) begin
      bc = 0;
      for (int c = 1; c < exp_done; c++) bc += int'(busy_log[c]);
      check({tag, " busy_cycles"}, bc, exp_done - 1);
      check({tag, " busy_at_start"}, int'(busy_log[0]), 0);
      check({tag, " busy_at_done"}, int'(busy_log[exp_done]), 0);
    end
  endtask

  typedef struct {
    string name;
    int    md;
    int    ad;
    bit    nz;
    int    exp_done;
  } vec_t;

  vec_t vecs[4];
  int   s_done_c, s_act_n, s_we_n, s_last_idx, s_exp_done;
  int   s_addr_q[$], s_exp_q[$];
  bit   found;

  initial begin
    vecs[0] = '{"zero_wait", 0, 0, 1'b0, T};
    vecs[1] = '{"mac_wait3", 3, 0, 1'b0, T + OPS * 3};
    vecs[2] = '{"mac1_act2", 1, 2, 1'b0, T + OPS + NO * 2};
    vecs[3] = '{"act1_noise", 0, 1, 1'b1, T + NO};

    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset w_addr", int'(w_addr), 0);
    check("reset outputs", int'({busy, done, mac_clr, mac_req, act_req, y_we, x_sel, y_idx}), 0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle busy", int'(busy), 0);

    for (int v = 0; v < 4; v++) begin
      run_layer(vecs[v].md, vecs[v].ad, vecs[v].nz, 1, 1);
      verify(vecs[v].name, vecs[v].exp_done, 1);
    end

    for (int r = 0; r < 3; r++) begin
      run_layer(-1, -1, 1'b1, 1, 1);
      verify($sformatf("random%0d", r), T + sum_delay, 1);
    end

    // start held for 40 cycles: layer one, then a fresh layer from the next IDLE cycle.
    run_layer(0, 0, 1'b0, 40, 2);
    verify("start_held", T, 2);
    check("start_held second_done", last_done, 2 * T + 1);
    check("start_held idle_gap", int'(busy_log[T + 1]), 0);
    check("start_held restart", int'(busy_log[T + 2]), 1);

    // Asynchronous reset while neuron 2 is in its MAC phase.
    clear_logs();
    md_cfg = 0; ad_cfg = 0; armed = 1; found = 0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (mac_req && int'(w_addr) == 2 * NI) begin
        found = 1;
        break;
      end
    end
    check("rst reached neuron2", int'(found), 1);
    rst_n = 1'b0;
    #1;
    check("rst async busy", int'(busy), 0);
    check("rst async w_addr", int'(w_addr), 0);
    check("rst async outputs", int'({busy, done, mac_clr, mac_req, act_req, y_we, x_sel, y_idx}), 0);
    repeat (5) @(negedge clk);
    check("rst no done", n_done, 0);
    #2 rst_n = 1'b1;
    armed = 0;
    run_layer(0, 0, 1'b0, 1, 1);
    verify("after_rst", T, 1);

    // Single-input, single-neuron instance with acks tied to their requests.
    s_exp_q.push_back(0);
    if (BIAS != 0) s_exp_q.push_back(1);
    s_exp_done = 1 * (2 * 1 + 2 + 2 * BIAS) + 1;
    s_done_c = -1; s_act_n = 0; s_we_n = 0; s_last_idx = -1;
    @(posedge clk); #2 s_start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 1) s_start = 1'b0;
      s_mac_ack = s_mac_req;
      s_act_ack = s_act_req;
      if (s_mac_req) s_addr_q.push_back(int'(s_w_addr));
      if (s_act_req) s_act_n++;
      if (s_y_we) begin
        s_we_n++;
        s_last_idx = int'(s_y_idx);
      end
      if (s_done && s_done_c < 0) s_done_c = c;
    end
    s_mac_ack = 1'b0; s_act_ack = 1'b0;
    check("small done_cycle", s_done_c, s_exp_done);
    check("small mac_reqs", s_addr_q.size(), s_exp_q.size());
    for (int k = 0; k < s_addr_q.size() && k < s_exp_q.size(); k++)
      check($sformatf("small mac%0d w_addr", k), s_addr_q[k], s_exp_q[k]);
    check("small act_req", s_act_n, 1);
    check("small y_we", s_we_n, 1);
    check("small y_idx", s_last_idx, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
